// File: rtl/bnn_act_packer_pkg.sv
// bnn_pkg: shared state type, error-bit indices and default widths for the BNNA activation packer
package bnn_pkg;

    typedef enum logic [1:0] {IDLE, PACK, FLUSH} pack_state_t;

    localparam int ERR_OVF      = 0;
    localparam int ERR_IDLE_BIT = 1;
    localparam int ERR_CFG      = 2;

    localparam int ACT_WORD_W   = 64;

endpackage

// File: rtl/bnn_act_packer_fifo2.sv
// bnn_pack_fifo2: 2-entry register FIFO of {last, word}; head entry drives the outputs directly
// Ports: clk, reset (async, active-low), push/din_word/din_last write side,
//        pop/dout_word/dout_last read side, full/empty status.
// A push while full lands only when a pop happens in the same cycle; a pop on empty is ignored.
module bnn_pack_fifo2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din_word,
    input  logic         din_last,
    output logic [W-1:0] dout_word,
    output logic         dout_last,
    output logic         full,
    output logic         empty
);

    logic [W:0] head, tail;
    logic [1:0] cnt;
    logic       do_pop, do_push;

    assign empty   = cnt == 2'd0;
    assign full    = cnt == 2'd2;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign {dout_last, dout_word} = head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (do_push && (cnt == 2'd0 || (cnt == 2'd1 && do_pop)))
                head <= {din_last, din_word};
            else if (do_pop && cnt == 2'd2)
                head <= tail;
            if (do_push && ((cnt == 2'd1 && !do_pop) || cnt == 2'd2))
                tail <= {din_last, din_word};
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/bnn_act_packer.sv
// bnn_act_packer: packs the serial binarized activation stream LSB-first into words for the next layer
// Ports: clk, reset (async, active-low)
//        cfg_start/cfg_len   start a layer of cfg_len bits
//        i_bit/i_bit_val     serial activation stream (cannot be stalled)
//        o_word/o_last/o_val/i_rdy  packed word stream out of a 2-entry FIFO
//        o_busy, o_done, o_err (sticky: [0] overflow, [1] bit while idle/flushing, [2] bad cfg), i_err_clr
// Optional macro BNN_ACT_PACK_POPCNT_EN adds o_popcnt, the count of 1 bits in the current/last layer.
module bnn_act_packer import bnn_pkg::*; #(
    parameter int WORD_W = ACT_WORD_W,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              i_bit,
    input  logic              i_bit_val,
    output logic [WORD_W-1:0] o_word,
    output logic              o_last,
    output logic              o_val,
    input  logic              i_rdy,
    output logic              o_busy,
    output logic              o_done,
    output logic [2:0]        o_err,
`ifdef BNN_ACT_PACK_POPCNT_EN
    input  logic              i_err_clr,
    output logic [LEN_W-1:0]  o_popcnt
`else
    input  logic              i_err_clr
`endif
);

    localparam int IDX_W = $clog2(WORD_W);

    pack_state_t       state, state_nx;
    logic [LEN_W-1:0]  len, bit_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [WORD_W-1:0] sreg, word_nx;
    logic              take_bit, is_last, complete, start_ok;
    logic              full, empty, pop_fire, drop;
    logic [2:0]        err_ev;

    assign take_bit = i_bit_val && state == PACK;
    assign is_last  = bit_cnt + LEN_W'(1) == len;
    assign complete = take_bit && (bit_idx == IDX_W'(WORD_W - 1) || is_last);
    assign word_nx  = sreg | (WORD_W'(i_bit) << bit_idx);
    assign start_ok = cfg_start && state == IDLE && cfg_len != '0;
    assign pop_fire = i_rdy && !empty;
    assign drop     = complete && full && !pop_fire;
    assign o_val    = !empty;
    assign o_busy   = state != IDLE;
    // FLUSH never pushes, so popping the sole remaining entry empties the FIFO.
    assign o_done   = state == FLUSH && pop_fire && !full;

    always_comb begin
        err_ev               = '0;
        err_ev[ERR_OVF]      = drop;
        err_ev[ERR_IDLE_BIT] = i_bit_val && state != PACK;
        err_ev[ERR_CFG]      = cfg_start && (o_busy || cfg_len == '0);
    end

    always_comb begin
        state_nx = state;
        if (start_ok)
            state_nx = PACK;
        else if (complete && is_last)
            state_nx = FLUSH;
        else if (o_done)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len     <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
            sreg    <= '0;
            o_err   <= '0;
        end else begin
            o_err <= (i_err_clr ? 3'b000 : o_err) | err_ev;
            if (start_ok) begin
                len     <= cfg_len;
                bit_cnt <= '0;
                bit_idx <= '0;
                sreg    <= '0;
            end else if (take_bit) begin
                bit_cnt <= bit_cnt + LEN_W'(1);
                bit_idx <= complete ? '0 : bit_idx + IDX_W'(1);
                sreg    <= complete ? '0 : word_nx;
            end
        end
    end

`ifdef BNN_ACT_PACK_POPCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            o_popcnt <= '0;
        else if (start_ok)
            o_popcnt <= '0;
        else if (take_bit && i_bit)
            o_popcnt <= o_popcnt + LEN_W'(1);
    end
`endif

    // A dropped final word still moves the FSM to FLUSH so the layer terminates.
    bnn_pack_fifo2 #(.W(WORD_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (complete),
        .pop       (i_rdy),
        .din_word  (word_nx),
        .din_last  (is_last),
        .dout_word (o_word),
        .dout_last (o_last),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_bnn_act_packer.sv
// tb_bnn_act_packer: randomized self-checking bench for bnn_act_packer against a word-chunking reference model
module tb_bnn_act_packer;

    localparam int W = 64;
    localparam int L = 16;

    logic          clk = 0, reset = 0, cfg_start = 0, i_bit = 0, i_bit_val = 0, i_rdy = 0, i_err_clr = 0;
    logic [L-1:0]  cfg_len = '0;
    logic [W-1:0]  o_word;
    logic          o_last, o_val, o_busy, o_done;
    logic [2:0]    o_err;
`ifdef BNN_ACT_PACK_POPCNT_EN
    logic [L-1:0]  o_popcnt;
`endif

    int total = 0, bad = 0, done_cnt = 0;
    logic [W:0] got_q[$];
    logic [W:0] exp_q[$];
    bit         bits_q[$];

    always #5 clk = ~clk;

    bnn_act_packer #(.WORD_W(W), .LEN_W(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_len   (cfg_len),
        .i_bit     (i_bit),
        .i_bit_val (i_bit_val),
        .o_word    (o_word),
        .o_last    (o_last),
        .o_val     (o_val),
        .i_rdy     (i_rdy),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err),
`ifdef BNN_ACT_PACK_POPCNT_EN
        .i_err_clr (i_err_clr),
        .o_popcnt  (o_popcnt)
`else
        .i_err_clr (i_err_clr)
`endif
    );

    // Inputs change 1 time unit after posedge, so at negedge both sides are settled.
    always @(negedge clk) begin
        if (o_val && i_rdy) got_q.push_back({o_last, o_word});
        if (o_done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input int len);
        cfg_len   = L'(len);
        cfg_start = 1;
        step();
        cfg_start = 0;
    endtask

    // Reference: chop the bit list into WORD_W chunks, bit i -> position i mod W, final chunk flagged last.
    task automatic make_exp();
        logic [W-1:0] w;
        int n;
        n = bits_q.size();
        w = '0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            w[i % W] = bits_q[i];
            if (i % W == W - 1 || i == n - 1) begin
                exp_q.push_back({(i == n - 1), w});
                w = '0;
            end
        end
    endtask

    task automatic send_bits(input bit gaps, input bit rnd_rdy);
        int i;
        i = 0;
        while (i < bits_q.size()) begin
            if (rnd_rdy) i_rdy = ($urandom_range(0, 3) != 0);
            if (gaps && $urandom_range(0, 3) == 0) begin
                i_bit_val = 0;
            end else begin
                i_bit_val = 1;
                i_bit     = bits_q[i];
                i++;
            end
            step();
        end
        i_bit_val = 0;
        i_bit     = 0;
    endtask

    task automatic wait_done(input string nm, input int d0, input bit rnd_rdy);
        bit ok;
        ok = 0;
        for (int n = 0; n < 3000; n++) begin
            if (done_cnt > d0 && !o_busy) begin
                ok = 1;
                break;
            end
            if (rnd_rdy) i_rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s done-wait: timed out, busy=%0b done_count=%0d", nm, o_busy, done_cnt - d0);
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL %s done-pulses: got %0d want 1", nm, done_cnt - d0);
        end
    endtask

    task automatic check_layer(input string nm, input int base);
        total++;
        if (got_q.size() - base != exp_q.size()) begin
            bad++;
            $display("FAIL %s word-count: got %0d want %0d", nm, got_q.size() - base, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++) begin
            total++;
            if (got_q[base + k] !== exp_q[k]) begin
                bad++;
                $display("FAIL %s word%0d: got last=%0b %h want last=%0b %h", nm, k,
                         got_q[base + k][W], got_q[base + k][W-1:0], exp_q[k][W], exp_q[k][W-1:0]);
            end
        end
    endtask

    task automatic check_err(input string nm, input logic [2:0] want);
        total++;
        if (o_err !== want) begin
            bad++;
            $display("FAIL %s o_err: got %b want %b", nm, o_err, want);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({o_word, o_last, o_val, o_busy, o_done, o_err} !== '0) begin
            bad++;
            $display("FAIL reset outputs: word=%h last=%b val=%b busy=%b done=%b err=%b want all 0",
                     o_word, o_last, o_val, o_busy, o_done, o_err);
        end
        step();
        reset = 1;
        step();
    endtask

    task automatic test_full_word();
        int d0;
        bit early;
        d0    = done_cnt;
        early = 0;
        i_rdy = 1;
        start_layer(64);
        for (int i = 0; i < 64; i++) begin
            if (o_val) early = 1;
            i_bit_val = 1;
            i_bit     = (i % 2 == 0);
            step();
        end
        i_bit_val = 0;
        total++;
        if (early) begin
            bad++;
            $display("FAIL full_word early-valid: got o_val=1 before last bit, want 0");
        end
        total++;
        if ({o_val, o_last, o_word} !== {1'b1, 1'b1, 64'h5555_5555_5555_5555}) begin
            bad++;
            $display("FAIL full_word latency-word: got val=%b last=%b %h want val=1 last=1 5555555555555555",
                     o_val, o_last, o_word);
        end
        total++;
        if (o_done !== 1'b1) begin
            bad++;
            $display("FAIL full_word done-same-cycle: got %b want 1", o_done);
        end
        step();
        total++;
        if ({o_busy, o_done, o_val} !== 3'b000) begin
            bad++;
            $display("FAIL full_word idle-after: got busy=%b done=%b val=%b want 000", o_busy, o_done, o_val);
        end
        check_err("full_word", 3'b000);
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL full_word done-pulses: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_partial_word();
        int base, d0;
        base = got_q.size();
        d0   = done_cnt;
        i_rdy = 1;
        bits_q.delete();
        for (int i = 0; i < 67; i++) bits_q.push_back(1'b1);
        make_exp();
        start_layer(67);
        send_bits(0, 0);
        wait_done("partial", d0, 0);
        check_layer("partial", base);
        check_err("partial", 3'b000);
    endtask

    task automatic test_backpressure();
        int base, d0;
        bit unstable;
        base = got_q.size();
        d0   = done_cnt;
        unstable = 0;
        i_rdy = 0;
        start_layer(192);
        for (int i = 0; i < 192; i++) begin
            i_bit_val = 1;
            i_bit     = 1;
            step();
            if (i >= 63 && {o_val, o_last, o_word} !== {1'b1, 1'b0, {W{1'b1}}}) unstable = 1;
        end
        i_bit_val = 0;
        total++;
        if (unstable) begin
            bad++;
            $display("FAIL backpressure hold: head changed while stalled, now val=%b last=%b %h", o_val, o_last, o_word);
        end
        check_err("backpressure", 3'b001);
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL backpressure flush-busy: got %b want 1", o_busy);
        end
        exp_q.delete();
        exp_q.push_back({1'b0, {W{1'b1}}});
        exp_q.push_back({1'b0, {W{1'b1}}});
        i_rdy = 1;
        wait_done("backpressure", d0, 0);
        check_layer("backpressure", base);
        i_err_clr = 1;
        step();
        i_err_clr = 0;
        check_err("backpressure clear", 3'b000);
    endtask

    task automatic test_protocol();
        int base, d0;
        i_rdy = 1;
        i_bit_val = 1;
        step();
        i_bit_val = 0;
        check_err("idle_bit", 3'b010);
        cfg_len   = '0;
        cfg_start = 1;
        step();
        cfg_start = 0;
        check_err("len_zero", 3'b110);
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL len_zero busy: got %b want 0", o_busy);
        end
        i_err_clr = 1;
        step();
        i_err_clr = 0;
        check_err("err_clr", 3'b000);
        base = got_q.size();
        d0   = done_cnt;
        start_layer(5);
        start_layer(3);
        check_err("start_busy", 3'b100);
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy busy: got %b want 1", o_busy);
        end
        bits_q.delete();
        for (int i = 0; i < 5; i++) bits_q.push_back(1'($urandom_range(0, 1)));
        make_exp();
        send_bits(0, 0);
        wait_done("start_busy", d0, 0);
        check_layer("start_busy", base);
        i_err_clr = 1;
        i_bit_val = 1;
        step();
        i_err_clr = 0;
        i_bit_val = 0;
        check_err("clr_vs_event", 3'b010);
        i_err_clr = 1;
        step();
        i_err_clr = 0;
        check_err("clr_final", 3'b000);
    endtask

    task automatic test_reset_mid();
        int base, d0;
        i_rdy = 1;
        i_bit_val = 1;
        step();
        i_bit_val = 0;
        start_layer(64);
        for (int i = 0; i < 10; i++) begin
            i_bit_val = 1;
            i_bit     = 1'($urandom_range(0, 1));
            step();
        end
        i_bit_val = 0;
        reset = 0;
        #1;
        total++;
        if ({o_word, o_last, o_val, o_busy, o_done, o_err} !== '0) begin
            bad++;
            $display("FAIL reset_mid outputs: word=%h last=%b val=%b busy=%b done=%b err=%b want all 0",
                     o_word, o_last, o_val, o_busy, o_done, o_err);
        end
        step();
        reset = 1;
        step();
        base = got_q.size();
        d0   = done_cnt;
        bits_q.delete();
        for (int i = 0; i < 64; i++) bits_q.push_back(1'($urandom_range(0, 1)));
        make_exp();
        start_layer(64);
        send_bits(0, 0);
        wait_done("reset_mid relayer", d0, 0);
        check_layer("reset_mid relayer", base);
        check_err("reset_mid relayer", 3'b000);
    endtask

    task automatic test_random();
        int lens[5] = '{1, 63, 64, 65, 128};
        int base, d0, len, ones;
        for (int k = 0; k < 10; k++) begin
            len  = (k < 5) ? lens[k] : $urandom_range(1, 300);
            base = got_q.size();
            d0   = done_cnt;
            ones = 0;
            bits_q.delete();
            for (int i = 0; i < len; i++) begin
                bits_q.push_back(1'($urandom_range(0, 1)));
                ones += bits_q[i];
            end
            make_exp();
            i_rdy = 1;
            start_layer(len);
            send_bits(1, 1);
            wait_done($sformatf("random%0d", k), d0, 1);
            check_layer($sformatf("random%0d", k), base);
            check_err($sformatf("random%0d", k), 3'b000);
`ifdef BNN_ACT_PACK_POPCNT_EN
            total++;
            if (o_popcnt !== L'(ones)) begin
                bad++;
                $display("FAIL random%0d popcnt: got %0d want %0d", k, o_popcnt, ones);
            end
`else
            if (ones < 0) $display("random%0d odd count", k);
`endif
        end
    endtask

`ifdef BNN_ACT_PACK_POPCNT_EN
    task automatic test_popcnt();
        int d0, j;
        bit t;
        d0 = done_cnt;
        bits_q.delete();
        for (int i = 0; i < 67; i++) bits_q.push_back(i < 40);
        for (int i = 66; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = bits_q[i];
            bits_q[i] = bits_q[j];
            bits_q[j] = t;
        end
        i_rdy = 1;
        start_layer(67);
        send_bits(0, 0);
        wait_done("popcnt", d0, 0);
        total++;
        if (o_popcnt !== L'(40)) begin
            bad++;
            $display("FAIL popcnt layer67: got %0d want 40", o_popcnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_word();
        test_partial_word();
        test_backpressure();
        test_protocol();
        test_reset_mid();
        test_random();
`ifdef BNN_ACT_PACK_POPCNT_EN
        test_popcnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
